// File: rtl/key_debounce_sched.sv
// key_debounce_sched
//
// Time-shared debounce controller for a bank of active-low push buttons. One
// stability timer is granted round-robin to whichever key's synchronized level
// differs from its debounced level. A level that holds for DEBOUNCE_CYC cycles
// is accepted and reported as a single press/release event over valid/ready.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous, active-low reset
//   ikey       raw button levels (active-low, asynchronous to clk)
//   key_state  debounced levels, 1 = released
//   ev_valid   event available
//   ev_ready   consumer accepts event
//   ev_key     index of the key that changed
//   ev_press   1 = press (1->0), 0 = release (0->1)
//   busy       timer granted (TIME or EMIT)

module key_debounce_sched #(
  parameter int unsigned N_KEYS       = 4,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned CNT_W        = 20,
  localparam int unsigned KW          = $clog2(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] ikey,
  output logic [N_KEYS-1:0] key_state,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [KW-1:0]     ev_key,
  output logic              ev_press,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StTime, StEmit} state_e;

  state_e            state_q, state_d;
  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] key_state_q, key_state_d;
  logic [N_KEYS-1:0] pending;
  logic [KW-1:0]     cur_q, cur_d;
  logic [KW-1:0]     last_q, last_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic              busy_q;
  logic [KW-1:0]     pick;
  logic              pick_vld;

  // Two-flop synchronizer; resets to the released level so no spurious
  // transitions appear when reset is released with keys idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= ikey;
      sync2_q <= sync1_q;
    end
  end

  assign pending = sync2_q ^ key_state_q;

  // Round-robin search starting just after the last granted key.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned off = 1; off <= N_KEYS; off++) begin
      idx = (32'(last_q) + off) % N_KEYS;
      if (!pick_vld && pending[idx]) begin
        pick     = KW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      last_q      <= KW'(N_KEYS - 1);
      timer_q     <= '0;
      key_state_q <= '1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      timer_q     <= timer_d;
      key_state_q <= key_state_d;
      busy_q      <= (state_d != StIdle);
    end
  end

  // Next-state logic. last is updated at grant time, so an abandoned key
  // has already advanced the round-robin pointer and cannot starve others.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    timer_d     = timer_q;
    key_state_d = key_state_q;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          cur_d   = pick;
          last_d  = pick;
          timer_d = '0;
          state_d = StTime;
        end
      end
      StTime: begin
        if (!pending[cur_q]) begin
          state_d = StIdle;
        end else if (timer_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
          key_state_d[cur_q] = sync2_q[cur_q];
          state_d            = StEmit;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      StEmit: begin
        if (ev_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs. key_state already holds the new level in EMIT, so a press is
  // reported when the accepted level is 0.
  always_comb begin
    ev_valid  = (state_q == StEmit);
    ev_key    = cur_q;
    ev_press  = ev_valid & ~key_state_q[cur_q];
    key_state = key_state_q;
    busy      = busy_q;
  end

endmodule

// File: tb/tb_key_debounce_sched.sv
module tb_key_debounce_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned D  = 16;
  localparam int unsigned CW = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ikey = 4'hF;
  logic       ev_ready = 1'b1;
  logic [3:0] key_state;
  logic       ev_valid;
  logic [1:0] ev_key;
  logic       ev_press;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int ecnt     = 0;

  key_debounce_sched #(
    .N_KEYS      (N),
    .DEBOUNCE_CYC(D),
    .CNT_W       (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ikey     (ikey),
    .key_state(key_state),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_key   (ev_key),
    .ev_press (ev_press),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  // Next rising edge becomes edge 0.
  task automatic origin();
    ecnt = -1;
  endtask

  task automatic wait_ev(input string tag, input int budget);
    int k;
    k = 0;
    while (!ev_valid && k < budget) begin
      step();
      k++;
    end
    if (!ev_valid) check({tag, "_timeout"}, 32'(ev_valid), 1);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ikey     = 4'hF;
    ev_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    int bad;

    // Reset values
    step();
    check("rst_key_state", 32'(key_state), 32'hF);
    check("rst_ev_valid", 32'(ev_valid), 0);
    check("rst_ev_key", 32'(ev_key), 0);
    check("rst_ev_press", 32'(ev_press), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    step();
    step();

    // Single press / release of key 2
    ikey = 4'b1011;
    origin();
    repeat (18) step();
    check("t1_novalid_e17", 32'(ev_valid), 0);
    check("t1_busy_e17", 32'(busy), 1);
    step();
    check("t1_edge", 32'(ecnt), 18);
    check("t1_valid", 32'(ev_valid), 1);
    check("t1_key", 32'(ev_key), 2);
    check("t1_press", 32'(ev_press), 1);
    check("t1_state", 32'(key_state), 32'hB);
    step();
    check("t1_pulse", 32'(ev_valid), 0);
    ikey = 4'hF;
    origin();
    wait_ev("t1r", 40);
    check("t1r_edge", 32'(ecnt), 18);
    check("t1r_key", 32'(ev_key), 2);
    check("t1r_press", 32'(ev_press), 0);
    check("t1r_state", 32'(key_state), 32'hF);
    step();

    // Glitch on key 1: 5 cycles low, then high
    ikey = 4'b1101;
    origin();
    repeat (5) step();
    check("t2_busy_glitch", 32'(busy), 1);
    ikey = 4'hF;
    origin();
    repeat (3) step();
    check("t2_busy_fall", 32'(busy), 0);
    seen = 0;
    repeat (30) begin
      step();
      if (ev_valid) seen++;
    end
    check("t2_noevent", 32'(seen), 0);
    check("t2_state", 32'(key_state), 32'hF);

    // Keys 0 and 3 on the same edge, last = 3 after reset
    do_reset();
    ikey = 4'b0110;
    origin();
    wait_ev("t3a", 40);
    check("t3a_edge", 32'(ecnt), 18);
    check("t3a_key", 32'(ev_key), 0);
    check("t3a_press", 32'(ev_press), 1);
    step();
    wait_ev("t3b", 40);
    check("t3b_edge", 32'(ecnt), 36);
    check("t3b_key", 32'(ev_key), 3);
    check("t3b_state", 32'(key_state), 32'h6);
    step();
    // Release key 0 alone so last becomes 0
    ikey = 4'b0111;
    origin();
    wait_ev("t3c", 40);
    check("t3c_key", 32'(ev_key), 0);
    check("t3c_press", 32'(ev_press), 0);
    step();
    // Key 0 press and key 3 release together, last = 0: key 3 first
    ikey = 4'b1110;
    origin();
    wait_ev("t3d", 40);
    check("t3d_edge", 32'(ecnt), 18);
    check("t3d_key", 32'(ev_key), 3);
    check("t3d_press", 32'(ev_press), 0);
    step();
    wait_ev("t3e", 40);
    check("t3e_edge", 32'(ecnt), 36);
    check("t3e_key", 32'(ev_key), 0);
    check("t3e_press", 32'(ev_press), 1);
    check("t3e_state", 32'(key_state), 32'hE);
    step();

    // Back-pressure: ev_ready low for 50 cycles
    do_reset();
    ev_ready = 1'b0;
    ikey = 4'b1101;
    origin();
    wait_ev("t4", 40);
    check("t4_edge", 32'(ecnt), 18);
    ikey = 4'b1001;
    bad = 0;
    repeat (50) begin
      step();
      if (!ev_valid || ev_key != 2'd1 || !ev_press || !busy || key_state != 4'b1101) bad++;
    end
    check("t4_stable", 32'(bad), 0);
    ev_ready = 1'b1;
    check("t4_valid_at_ready", 32'(ev_valid), 1);
    origin();
    step();
    check("t4_handshake", 32'(ev_valid), 0);
    wait_ev("t4b", 40);
    check("t4b_edge", 32'(ecnt), 17);
    check("t4b_key", 32'(ev_key), 2);
    check("t4b_state", 32'(key_state), 32'h9);
    step();

    // Key 0 chatters while key 1 holds low
    do_reset();
    ikey = 4'b1100;
    origin();
    while (!ev_valid && ecnt < 80) begin
      step();
      if (ecnt % 4 == 3) ikey[0] = ~ikey[0];
    end
    check("t5_valid", 32'(ev_valid), 1);
    check("t5_key", 32'(ev_key), 1);
    check("t5_press", 32'(ev_press), 1);
    check("t5_latency_ok", 32'(ecnt <= int'(2 * (D + 3))), 1);
    check("t5_key0_state", 32'(key_state[0]), 1);
    ikey = 4'hF;
    step();

    // Reset at timer = 10 of a key 2 press
    do_reset();
    ikey = 4'b1011;
    origin();
    repeat (13) step();
    check("t6_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 0);
    check("t6_valid", 32'(ev_valid), 0);
    check("t6_key", 32'(ev_key), 0);
    check("t6_press", 32'(ev_press), 0);
    check("t6_state", 32'(key_state), 32'hF);
    step();
    step();
    ev_ready = 1'b0;
    rst_n = 1'b1;
    origin();
    wait_ev("t6b", 40);
    check("t6b_edge", 32'(ecnt), 18);
    check("t6b_key", 32'(ev_key), 2);
    check("t6b_press", 32'(ev_press), 1);
    // Reset while the event is pending discards it
    step();
    rst_n = 1'b0;
    #1;
    check("t6c_valid", 32'(ev_valid), 0);
    check("t6c_state", 32'(key_state), 32'hF);
    ikey = 4'hF;
    ev_ready = 1'b1;
    step();
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      step();
      if (ev_valid) seen++;
    end
    check("t6c_noevent", 32'(seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
